// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/sub over a DIGIT-bit slice.
// Result, carry and signed overflow land together on done.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_amsb;
  logic             r_bmsb;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_bsel;
  logic [DIGIT:0]   w_dig;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_res;

  // Start is only honoured when no operation is in flight.
  assign w_accept = i_start && (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);

  // Subtract is add of the inverted operand with inverted carry-in.
  assign w_bsel = i_sub ? ~i_b : i_b;

  // One slice of the adder plus the result shift-in from the top.
  assign w_dig = {1'b0, r_a[DIGIT-1:0]}
               + {1'b0, r_b[DIGIT-1:0]}
               + (DIGIT+1)'(r_carry);
  assign w_top = WIDTH'(w_dig[DIGIT-1:0]) << (WIDTH - DIGIT);
  assign w_res = (r_res >> DIGIT) | w_top;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; DONE lasts one cycle unless restarted.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_RUN;
      S_RUN:   if (r_cnt == LAST) w_next = S_DONE;
      S_DONE:  w_next = i_start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_RUN:   o_busy = 1'b1;
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture and per-digit shifting datapath.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= w_bsel;
      r_res   <= '0;
      r_carry <= i_cin ^ i_sub;
      r_cnt   <= '0;
      r_amsb  <= i_a[WIDTH-1];
      r_bmsb  <= w_bsel[WIDTH-1];
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_res   <= w_res;
      r_carry <= w_dig[DIGIT];
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Visible result registers, updated only on the last digit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_last) begin
      r_sum  <= w_res;
      r_cout <= w_dig[DIGIT];
      r_ovf  <= (r_amsb == r_bmsb) && (w_res[WIDTH-1] != r_amsb);
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench over four configurations.
// (8,1) (8,4) (16,4) (32,8) share clock and reset.
module tb_serial_adder;

  typedef struct packed {
    logic        cout;
    logic        ovf;
    logic [31:0] sum;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  start_v = '0;
  logic [3:0]  sub_v = '0;
  logic [3:0]  cin_v = '0;
  logic [31:0] a_v [4];
  logic [31:0] b_v [4];
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [3:0]  cout_v;
  logic [3:0]  ovf_v;
  logic [31:0] sum_v [4];
  logic [7:0]  s0;
  logic [7:0]  s1;
  logic [15:0] s2;
  logic [31:0] s3;

  int wid [4] = '{8, 8, 16, 32};
  exp_t q [4][$];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign sum_v[0] = 32'(s0);
  assign sum_v[1] = 32'(s1);
  assign sum_v[2] = 32'(s2);
  assign sum_v[3] = s3;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[0]),
    .i_sub(sub_v[0]), .i_a(a_v[0][7:0]), .i_b(b_v[0][7:0]),
    .i_cin(cin_v[0]), .o_busy(busy_v[0]), .o_done(done_v[0]),
    .o_sum(s0), .o_cout(cout_v[0]), .o_ovf(ovf_v[0])
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[1]),
    .i_sub(sub_v[1]), .i_a(a_v[1][7:0]), .i_b(b_v[1][7:0]),
    .i_cin(cin_v[1]), .o_busy(busy_v[1]), .o_done(done_v[1]),
    .o_sum(s1), .o_cout(cout_v[1]), .o_ovf(ovf_v[1])
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u2 (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[2]),
    .i_sub(sub_v[2]), .i_a(a_v[2][15:0]), .i_b(b_v[2][15:0]),
    .i_cin(cin_v[2]), .o_busy(busy_v[2]), .o_done(done_v[2]),
    .o_sum(s2), .o_cout(cout_v[2]), .o_ovf(ovf_v[2])
  );

  serial_adder #(.WIDTH(32), .DIGIT(8)) u3 (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[3]),
    .i_sub(sub_v[3]), .i_a(a_v[3]), .i_b(b_v[3]),
    .i_cin(cin_v[3]), .o_busy(busy_v[3]), .o_done(done_v[3]),
    .o_sum(s3), .o_cout(cout_v[3]), .o_ovf(ovf_v[3])
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int k,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic s,
                                 input logic c);
    int w;
    logic [32:0] m, am, bm, f;
    exp_t e;
    w = wid[k];
    m = (33'd1 << w) - 33'd1;
    am = {1'b0, a} & m;
    bm = {1'b0, (s ? ~b : b)} & m;
    f = am + bm + {32'd0, c ^ s};
    e.sum = f[31:0] & m[31:0];
    e.cout = f[w];
    e.ovf = (am[w-1] == bm[w-1]) && (e.sum[w-1] != am[w-1]);
    return e;
  endfunction

  function automatic logic [63:0] obs(input int k);
    return 64'({cout_v[k], ovf_v[k], sum_v[k]});
  endfunction

  function automatic logic [63:0] ex(input logic co,
                                     input logic ov,
                                     input logic [31:0] s);
    return 64'({co, ov, s});
  endfunction

  // Scoreboard: every done pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (done_v[k] === 1'b1) begin
        chk("busy_with_done", 64'(busy_v[k]), 64'd0);
        if (q[k].size() == 0) begin
          chk("unexpected_done", 64'(done_v[k]), 64'd0);
        end else begin
          e = q[k].pop_front();
          chk($sformatf("result_u%0d", k), obs(k), 64'(e));
        end
      end
    end
  end

  task automatic drive(input int k,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic s,
                       input logic c,
                       input bit push);
    @(negedge clk);
    a_v[k] = a;
    b_v[k] = b;
    sub_v[k] = s;
    cin_v[k] = c;
    start_v[k] = 1'b1;
    if (push) q[k].push_back(model(k, a, b, s, c));
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k,
                           output int cyc,
                           output int nbusy);
    cyc = 0;
    nbusy = int'(busy_v[k]);
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done_v[k]) break;
      if (busy_v[k]) nbusy++;
    end
    chk("done_timeout", 64'(done_v[k]), 64'd1);
  endtask

  task automatic rand_run(input int k);
    int cyc, nb;
    for (int i = 0; i < 2000; i++) begin
      drive(k, $urandom, $urandom,
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b1);
      wait_done(k, cyc, nb);
    end
  endtask

  initial begin
    int cyc, nb, g;
    for (int k = 0; k < 4; k++) begin
      a_v[k] = '0;
      b_v[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("reset_state",
          64'({busy_v[k], done_v[k], cout_v[k], ovf_v[k], sum_v[k]}),
          64'd0);
    end
    rst = 1'b0;

    drive(0, 32'h3C, 32'h45, 1'b0, 1'b0, 1'b1);
    wait_done(0, cyc, nb);
    chk("add_latency", 64'(cyc), 64'd8);
    chk("add_busy_cycles", 64'(nb), 64'd8);
    chk("add_out", obs(0), ex(1'b0, 1'b1, 32'h81));
    @(negedge clk);
    chk("done_pulse_width", 64'(done_v[0]), 64'd0);

    drive(0, 32'h10, 32'h20, 1'b1, 1'b0, 1'b1);
    wait_done(0, cyc, nb);
    chk("sub_borrow", obs(0), ex(1'b0, 1'b0, 32'hF0));
    drive(0, 32'h20, 32'h10, 1'b1, 1'b1, 1'b1);
    wait_done(0, cyc, nb);
    chk("sub_bin", obs(0), ex(1'b1, 1'b0, 32'h0F));

    drive(1, 32'hFF, 32'h01, 1'b0, 1'b1, 1'b1);
    wait_done(1, cyc, nb);
    chk("d4_latency", 64'(cyc), 64'd2);
    chk("d4_wrap", obs(1), ex(1'b1, 1'b0, 32'h01));
    drive(1, 32'h7F, 32'h01, 1'b0, 1'b0, 1'b1);
    wait_done(1, cyc, nb);
    chk("d4_ovf", obs(1), ex(1'b0, 1'b1, 32'h80));

    drive(0, 32'h05, 32'h03, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    drive(0, 32'hAA, 32'h55, 1'b1, 1'b1, 1'b0);
    wait_done(0, cyc, nb);
    chk("ignored_start_out", obs(0), ex(1'b0, 1'b0, 32'h08));
    repeat (12) @(negedge clk);
    chk("ignored_start_idle", 64'(busy_v[0]), 64'd0);

    @(negedge clk);
    a_v[0] = 32'h11;
    b_v[0] = 32'h22;
    sub_v[0] = 1'b0;
    cin_v[0] = 1'b0;
    start_v[0] = 1'b1;
    q[0].push_back(model(0, 32'h11, 32'h22, 1'b0, 1'b0));
    wait_done(0, cyc, nb);
    a_v[0] = 32'h40;
    b_v[0] = 32'h50;
    q[0].push_back(model(0, 32'h40, 32'h50, 1'b0, 1'b0));
    g = 0;
    while (g < 200) begin
      @(negedge clk);
      g++;
      if (g == 1) start_v[0] = 1'b0;
      if (done_v[0]) break;
    end
    chk("b2b_gap", 64'(g), 64'd9);
    chk("b2b_out", obs(0), ex(1'b0, 1'b1, 32'h90));

    drive(0, 32'h12, 32'h34, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_u0",
        64'({busy_v[0], done_v[0], cout_v[0], ovf_v[0], sum_v[0]}),
        64'd0);
    chk("async_rst_u1", obs(1), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("aborted_idle", 64'(busy_v[0]), 64'd0);
    drive(0, 32'hC8, 32'h64, 1'b1, 1'b0, 1'b1);
    wait_done(0, cyc, nb);
    chk("post_rst_latency", 64'(cyc), 64'd8);

    fork
      rand_run(0);
      rand_run(2);
      rand_run(3);
    join
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("queue_empty_u%0d", k), 64'(q[k].size()), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
